// File: rtl/sampler_pkg.sv
// rtl/sampler_pkg.sv - shared ADC sample constants and pair-FSM encoding
package sampler_pkg;

  localparam int ADC_W  = 12;
  localparam int OFFSET = 2048;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    HAVE_V = 2'd1,
    HAVE_I = 2'd2
  } pair_state_t;

endpackage

// File: rtl/vi_pair_sync.sv
// rtl/vi_pair_sync.sv - pairs voltage/current strobes, flags a channel arriving twice
module vi_pair_sync
  import sampler_pkg::*;
#(
  parameter int W = ADC_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clear,
  input  logic         v_valid,
  input  logic [W-1:0] v_data,
  input  logic         i_valid,
  input  logic [W-1:0] i_data,
  output logic         pair_valid,
  output logic [W-1:0] pair_v,
  output logic [W-1:0] pair_i,
  output logic         overrun_evt
);

  pair_state_t  state;
  logic [W-1:0] v_hold;
  logic [W-1:0] i_hold;

  // Pair is presented in the strobe cycle so the first pipeline stage registers it.
  always_comb begin
    pair_valid  = 1'b0;
    pair_v      = v_data;
    pair_i      = i_data;
    overrun_evt = 1'b0;
    if (!clear) begin
      case (state)
        IDLE: pair_valid = v_valid & i_valid;
        HAVE_V: begin
          pair_valid  = i_valid;
          overrun_evt = v_valid;
          if (!v_valid) pair_v = v_hold;
        end
        HAVE_I: begin
          pair_valid  = v_valid;
          overrun_evt = i_valid;
          if (!i_valid) pair_i = i_hold;
        end
        default: pair_valid = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= IDLE;
      v_hold <= '0;
      i_hold <= '0;
    end else if (clear) begin
      state  <= IDLE;
      v_hold <= '0;
      i_hold <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (v_valid && !i_valid) begin
            v_hold <= v_data;
            state  <= HAVE_V;
          end else if (i_valid && !v_valid) begin
            i_hold <= i_data;
            state  <= HAVE_I;
          end
        end
        HAVE_V: begin
          if (i_valid)      state  <= IDLE;
          else if (v_valid) v_hold <= v_data;
        end
        HAVE_I: begin
          if (v_valid)      state  <= IDLE;
          else if (i_valid) i_hold <= i_data;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: rtl/power_accum.sv
// rtl/power_accum.sv - offset removal, V*I / V^2 / I^2 pipeline and windowed sums
module power_accum #(
  parameter int ADC_W  = sampler_pkg::ADC_W,
  parameter int OFFSET = sampler_pkg::OFFSET,
  parameter int N_LOG2 = 8,
  parameter int ACC_W  = 2*ADC_W+N_LOG2+1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              v_valid,
  input  logic [ADC_W-1:0]  v_data,
  input  logic              i_valid,
  input  logic [ADC_W-1:0]  i_data,
  output logic [ACC_W-1:0]  p_sum,
  output logic [ACC_W-1:0]  v2_sum,
  output logic [ACC_W-1:0]  i2_sum,
  output logic              window_done,
  output logic [N_LOG2-1:0] sample_cnt,
  output logic              overrun
);

  localparam int P_W = 2*ADC_W+2;
  localparam logic [ADC_W:0] OFF_C = (ADC_W+1)'(OFFSET);

  logic              pair_valid;
  logic              overrun_evt;
  logic [ADC_W-1:0]  pair_v;
  logic [ADC_W-1:0]  pair_i;

  logic                    s1_valid;
  logic signed [ADC_W:0]   s1_v;
  logic signed [ADC_W:0]   s1_i;
  logic                    s2_valid;
  logic signed [P_W-1:0]   s2_p;
  logic signed [P_W-1:0]   s2_v2;
  logic signed [P_W-1:0]   s2_i2;
  logic signed [ACC_W-1:0] acc_p;
  logic [ACC_W-1:0]        acc_v2;
  logic [ACC_W-1:0]        acc_i2;
  logic signed [ACC_W-1:0] p_next;
  logic [ACC_W-1:0]        v2_next;
  logic [ACC_W-1:0]        i2_next;
  logic                    window_last;

  vi_pair_sync #(.W(ADC_W)) u_pair (
    .clk         (clk),
    .rst         (rst),
    .clear       (clear),
    .v_valid     (v_valid),
    .v_data      (v_data),
    .i_valid     (i_valid),
    .i_data      (i_data),
    .pair_valid  (pair_valid),
    .pair_v      (pair_v),
    .pair_i      (pair_i),
    .overrun_evt (overrun_evt)
  );

  // Squares are non-negative, so sign extension of the full product equals zero extension.
  always_comb begin
    p_next      = acc_p  + {{(ACC_W-P_W){s2_p[P_W-1]}},  s2_p};
    v2_next     = acc_v2 + {{(ACC_W-P_W){s2_v2[P_W-1]}}, s2_v2};
    i2_next     = acc_i2 + {{(ACC_W-P_W){s2_i2[P_W-1]}}, s2_i2};
    window_last = s2_valid && (sample_cnt == '1);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_valid    <= 1'b0;
      s1_v        <= '0;
      s1_i        <= '0;
      s2_valid    <= 1'b0;
      s2_p        <= '0;
      s2_v2       <= '0;
      s2_i2       <= '0;
      acc_p       <= '0;
      acc_v2      <= '0;
      acc_i2      <= '0;
      p_sum       <= '0;
      v2_sum      <= '0;
      i2_sum      <= '0;
      window_done <= 1'b0;
      sample_cnt  <= '0;
      overrun     <= 1'b0;
    end else if (clear) begin
      s1_valid    <= 1'b0;
      s2_valid    <= 1'b0;
      acc_p       <= '0;
      acc_v2      <= '0;
      acc_i2      <= '0;
      window_done <= 1'b0;
      sample_cnt  <= '0;
      overrun     <= 1'b0;
    end else begin
      window_done <= 1'b0;
      s1_valid    <= pair_valid;
      if (pair_valid) begin
        s1_v <= $signed({1'b0, pair_v} - OFF_C);
        s1_i <= $signed({1'b0, pair_i} - OFF_C);
      end
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_p  <= s1_v * s1_i;
        s2_v2 <= s1_v * s1_v;
        s2_i2 <= s1_i * s1_i;
      end
      if (overrun_evt) overrun <= 1'b1;
      if (s2_valid) begin
        sample_cnt <= sample_cnt + N_LOG2'(1);
        if (window_last) begin
          p_sum       <= p_next;
          v2_sum      <= v2_next;
          i2_sum      <= i2_next;
          window_done <= 1'b1;
          acc_p       <= '0;
          acc_v2      <= '0;
          acc_i2      <= '0;
        end else begin
          acc_p  <= p_next;
          acc_v2 <= v2_next;
          acc_i2 <= i2_next;
        end
      end
    end
  end

endmodule

// File: doc/power_accum.md
Name: power_accum

Overview:
- Consumes paired 12-bit voltage and current ADC samples produced by the sampler's two MCP3201 SPI channels.
- Removes the mid-scale offset from each sample and computes instantaneous power, V² and I².
- Accumulates these over a window of 2^N_LOG2 sample pairs and presents the window sums for downstream mean/RMS computation.
- Sits directly downstream of the sampler; one pair is expected per conversion start.

Parameters:
ADC_W, 12, sample width from each ADC channel.
OFFSET, 2048, mid-scale code subtracted from each sample to give a signed value.
N_LOG2, 8, log2 of window length (samples per window).
ACC_W, 2*ADC_W+N_LOG2+1, width of every accumulator and result.

Ports:
clk  in  1  system clock.
rst  in  1  asynchronous active-low reset.
clear  in  1  synchronous clear of window, pairing and pipeline; highest priority after reset.
v_valid  in  1  one-cycle strobe, v_data valid.
v_data  in  ADC_W  voltage sample code.
i_valid  in  1  one-cycle strobe, i_data valid.
i_data  in  ADC_W  current sample code.
p_sum  out  ACC_W  signed sum of v*i over last completed window.
v2_sum  out  ACC_W  unsigned sum of v².
i2_sum  out  ACC_W  unsigned sum of i².
window_done  out  1  one-cycle pulse when the three sums update.
sample_cnt  out  N_LOG2  pairs accumulated in the current window.
overrun  out  1  sticky; a channel delivered twice before its partner arrived.

Behaviour:
Reset values:
- All outputs, accumulators, holding registers and pipeline valids reset to 0.
- Pair FSM resets to IDLE.

Pair FSM states: IDLE, HAVE_V, HAVE_I.
- IDLE:
  - v_valid & i_valid: pair forms immediately; stay in IDLE.
  - v_valid only: latch v_data, go to HAVE_V.
  - i_valid only: latch i_data, go to HAVE_I.
- HAVE_V:
  - i_valid: pair forms with held v; go to IDLE.
  - v_valid & i_valid: held v is replaced by new v_data; pair forms with new v; overrun set; go to IDLE.
  - v_valid only: replace held v, set overrun, stay in HAVE_V.
- HAVE_I: mirror image of HAVE_V.

Pipeline (each stage registered, valid bit travels with data, no backpressure):
- S1, pair formed: v_s = v - OFFSET, i_s = i - OFFSET, each ADC_W+1 signed; range -2048..+2047.
- S2: p = v_s*i_s (signed, 2*ADC_W+2 bits); v2 = v_s², i2 = i_s² (unsigned, 2*ADC_W bits).
- S3: accumulate; sample_cnt increments.
- Latency from pair-forming cycle to accumulator update is 3 clocks.
- Accumulators cannot overflow at ACC_W.

Window boundary:
- When the accumulate cycle brings the count to 2^N_LOG2:
  - p_sum/v2_sum/i2_sum load the final sums, including that product.
  - window_done pulses the following cycle, aligned with the new sums.
  - Accumulators and sample_cnt restart from 0; sample_cnt wraps to 0.
- Outputs hold their values until the next window completes.

Clear:
- Zeroes accumulators, sample_cnt, holding registers, pipeline valids and overrun.
- FSM returns to IDLE.
- Does not alter p_sum/v2_sum/i2_sum; no window_done.
- A strobe coincident with clear is discarded.

Reset mid-operation: asynchronous; everything returns to reset values immediately.

overrun clears only on reset or clear.

Decomposition:
- Shared package (sampler_pkg): ADC_W, OFFSET, pair-FSM state encoding.
- One natural sub-module: vi_pair_sync (pair FSM plus holding registers, outputs a paired strobe and overrun event).
- The arithmetic pipeline and accumulators stay in power_accum.

Test Plan:
1. N_LOG2=2; four simultaneous pairs v=3048, i=2548 -> window_done once; p_sum=2000000, v2_sum=4000000, i2_sum=1000000, sample_cnt back to 0.
2. Four pairs v=1048, i=2548 -> p_sum=-2000000, v2_sum=4000000, i2_sum=1000000.
3. Skewed arrival: v_valid, then i_valid 5 cycles later, repeated 4 times with v=3048, i=2548 -> sums as in scenario 1; overrun=0; accumulator updates 3 cycles after each i_valid.
4. v_valid twice (v=4095, then v=3048) before i_valid (i=2548) -> overrun=1 and stays 1; pair uses v=3048.
5. Two pairs accumulated, then clear, then four pairs v=i=2048 -> sample_cnt reads 0 after clear; next window_done gives all sums 0; prior window outputs unchanged until then.
6. rst low asynchronously mid-window with HAVE_I pending -> all outputs 0 the same cycle; after release, four pairs complete a fresh window correctly.
